ahb_arb2: RTL and testbench

//  Two-master AHB-Lite arbiter/mux that shares one single-port AHB slave (the on-chip RAM)

---
 rtl/ahb_arb2_if.sv | 28 ++
 rtl/ahb_arb2.sv | 158 +++++++++++++++
 tb/tb_ahb_arb2.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_arb2_if.sv
// AHB-Lite port bundle shared by the two master-facing ports and the
// slave-facing port of the arbiter. A bus master drives the "master"
// modport and an AHB-Lite slave (or the arbiter's upstream side) takes
// the "slave" modport.
interface ahb_arb2_if #(
  parameter int ADDR_W = 32
) ();
  logic              hsel;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [ADDR_W-1:0] haddr;
  logic [31:0]       hwdata;
  logic [31:0]       hrdata;
  logic              hready;
  logic [1:0]        hresp;
  logic              hready_in;

  modport master (
    output hsel, htrans, hwrite, hsize, haddr, hwdata, hready_in,
    input  hrdata, hready, hresp
  );

  modport slave (
    input  hsel, htrans, hwrite, hsize, haddr, hwdata,
    output hrdata, hready, hresp
  );
endinterface

// File: rtl/ahb_arb2.sv
// Two-master AHB-Lite arbiter/mux in front of one single-port slave (the
// on-chip RAM). Master 0 is instruction fetch, master 1 is load/store.
// A request that cannot be issued in its own cycle is parked in a
// one-entry buffer for that master and the master is stalled through its
// hready until the parked request is issued. The winner of a cycle is
// presented to the slave in the same cycle (no added latency).
module ahb_arb2 #(
  parameter bit RR_EN  = 1'b1,
  parameter int ADDR_W = 32
) (
  input  logic       hclk,
  input  logic       hreset_n,
  ahb_arb2_if.slave  m0,
  ahb_arb2_if.slave  m1,
  ahb_arb2_if.master s
);

  // Per-master views of the upstream ports so both masters share one
  // generate body.
  logic              sel_in     [2];
  logic [1:0]        trans_in   [2];
  logic              write_in   [2];
  logic [2:0]        size_in    [2];
  logic [ADDR_W-1:0] addr_in    [2];
  logic              hready_out [2];
  logic [1:0]        hresp_out  [2];

  assign sel_in[0]   = m0.hsel;
  assign sel_in[1]   = m1.hsel;
  assign trans_in[0] = m0.htrans;
  assign trans_in[1] = m1.htrans;
  assign write_in[0] = m0.hwrite;
  assign write_in[1] = m1.hwrite;
  assign size_in[0]  = m0.hsize;
  assign size_in[1]  = m1.hsize;
  assign addr_in[0]  = m0.haddr;
  assign addr_in[1]  = m1.haddr;

  assign m0.hready = hready_out[0];
  assign m1.hready = hready_out[1];
  assign m0.hresp  = hresp_out[0];
  assign m1.hresp  = hresp_out[1];
  // Read data is broadcast; only the data-phase owner samples it.
  assign m0.hrdata = s.hrdata;
  assign m1.hrdata = s.hrdata;

  // Arbitration and data-phase state.
  logic [1:0]        pend;
  logic [1:0]        accept;
  logic [1:0]        cand;
  logic [1:0]        own_dp;
  logic [1:0]        won;
  logic              eff_write  [2];
  logic [2:0]        eff_size   [2];
  logic [ADDR_W-1:0] eff_addr   [2];

  logic              grant;
  logic              winner;
  logic              win_write;
  logic [2:0]        win_size;
  logic [ADDR_W-1:0] win_addr;

  logic              dp_valid_reg;
  logic              dp_owner_reg;
  logic              last_grant_reg;
  logic              hold_write_reg;
  logic [2:0]        hold_size_reg;
  logic [ADDR_W-1:0] hold_addr_reg;

  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    logic              pend_reg;
    logic              pend_write_reg;
    logic [2:0]        pend_size_reg;
    logic [ADDR_W-1:0] pend_addr_reg;

    assign pend[gi]   = pend_reg;
    assign own_dp[gi] = dp_valid_reg & (dp_owner_reg == 1'(gi));

    // A parked request stalls its master; otherwise the master only waits
    // on the slave while it owns the data phase.
    assign hready_out[gi] = pend_reg    ? 1'b0 :
                            own_dp[gi]  ? s.hready : 1'b1;
    assign hresp_out[gi]  = own_dp[gi]  ? s.hresp : 2'b00;

    assign accept[gi] = sel_in[gi] & trans_in[gi][1] & hready_out[gi];
    assign cand[gi]   = pend_reg | accept[gi];
    assign won[gi]    = grant & (winner == 1'(gi));

    // Parked request takes precedence over the live bus: they never
    // coexist because parking drops hready_out.
    assign eff_write[gi] = pend_reg ? pend_write_reg : write_in[gi];
    assign eff_size[gi]  = pend_reg ? pend_size_reg  : size_in[gi];
    assign eff_addr[gi]  = pend_reg ? pend_addr_reg  : addr_in[gi];

    // Park an accepted request that was not issued; release it when issued.
    always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
        pend_reg       <= 1'b0;
        pend_write_reg <= 1'b0;
        pend_size_reg  <= 3'b000;
        pend_addr_reg  <= '0;
      end else if (won[gi]) begin
        pend_reg <= 1'b0;
      end else if (accept[gi]) begin
        pend_reg       <= 1'b1;
        pend_write_reg <= write_in[gi];
        pend_size_reg  <= size_in[gi];
        pend_addr_reg  <= addr_in[gi];
      end
    end
  end

  // Pick one candidate per cycle; only issue while the slave is ready.
  always_comb begin
    grant = s.hready & (cand[0] | cand[1]);
    if (cand[0] & cand[1]) begin
      winner = RR_EN ? ~last_grant_reg : 1'b0;
    end else begin
      winner = cand[1];
    end
  end

  assign win_write = eff_write[winner];
  assign win_size  = eff_size[winner];
  assign win_addr  = eff_addr[winner];

  // Slave side: zero-latency issue of the winner, otherwise IDLE with the
  // last issued control held stable.
  assign s.hsel      = grant;
  assign s.htrans    = grant ? 2'b10 : 2'b00;
  assign s.hwrite    = grant ? win_write : hold_write_reg;
  assign s.hsize     = grant ? win_size  : hold_size_reg;
  assign s.haddr     = grant ? win_addr  : hold_addr_reg;
  assign s.hwdata    = dp_owner_reg ? m1.hwdata : m0.hwdata;
  assign s.hready_in = s.hready;

  // Track the data-phase owner, the round-robin pointer and the held control.
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      last_grant_reg <= 1'b1;
      dp_valid_reg   <= 1'b0;
      dp_owner_reg   <= 1'b0;
      hold_write_reg <= 1'b0;
      hold_size_reg  <= 3'b000;
      hold_addr_reg  <= '0;
    end else if (grant) begin
      last_grant_reg <= winner;
      dp_valid_reg   <= 1'b1;
      dp_owner_reg   <= winner;
      hold_write_reg <= win_write;
      hold_size_reg  <= win_size;
      hold_addr_reg  <= win_addr;
    end else if (s.hready) begin
      dp_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ahb_arb2.sv
// Bench for ahb_arb2: a round-robin instance and a fixed-priority instance,
// each with its own pair of masters, sharing one slave response stream.
// Directed scenarios plus randomized traffic checked against a
// transaction-level model of the arbitration rules.
module tb_ahb_arb2;

  logic hclk = 1'b0;
  logic hreset_n;
  always #5 hclk = ~hclk;

  // Slave responses, shared by both instances.
  logic        s_hready;
  logic [1:0]  s_hresp;
  logic [31:0] s_hrdata;

  // Master drive, index k = dut*2 + master (dut 0 = round-robin, 1 = fixed).
  logic        d_sel   [4];
  logic [1:0]  d_trans [4];
  logic        d_wr    [4];
  logic [2:0]  d_sz    [4];
  logic [31:0] d_addr  [4];
  logic [31:0] d_wdata [4];

  logic        o_rdy    [4];
  logic [1:0]  o_resp   [4];
  logic [31:0] o_rdata  [4];
  logic        o_ssel   [2];
  logic [1:0]  o_strans [2];
  logic [31:0] o_saddr  [2];
  logic        o_swr    [2];
  logic [2:0]  o_ssz    [2];
  logic [31:0] o_swdata [2];

  ahb_arb2_if #(.ADDR_W(32)) mif [4] ();
  ahb_arb2_if #(.ADDR_W(32)) sif [2] ();

  for (genvar gi = 0; gi < 4; gi++) begin : g_mdrv
    assign mif[gi].hsel      = d_sel[gi];
    assign mif[gi].htrans    = d_trans[gi];
    assign mif[gi].hwrite    = d_wr[gi];
    assign mif[gi].hsize     = d_sz[gi];
    assign mif[gi].haddr     = d_addr[gi];
    assign mif[gi].hwdata    = d_wdata[gi];
    assign mif[gi].hready_in = mif[gi].hready;
    assign o_rdy[gi]         = mif[gi].hready;
    assign o_resp[gi]        = mif[gi].hresp;
    assign o_rdata[gi]       = mif[gi].hrdata;
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_sdrv
    assign sif[gi].hrdata = s_hrdata;
    assign sif[gi].hready = s_hready;
    assign sif[gi].hresp  = s_hresp;
    assign o_ssel[gi]     = sif[gi].hsel;
    assign o_strans[gi]   = sif[gi].htrans;
    assign o_saddr[gi]    = sif[gi].haddr;
    assign o_swr[gi]      = sif[gi].hwrite;
    assign o_ssz[gi]      = sif[gi].hsize;
    assign o_swdata[gi]   = sif[gi].hwdata;
  end

  ahb_arb2 #(.RR_EN(1'b1), .ADDR_W(32)) dut_rr (
    .hclk(hclk), .hreset_n(hreset_n), .m0(mif[0]), .m1(mif[1]), .s(sif[0])
  );

  ahb_arb2 #(.RR_EN(1'b0), .ADDR_W(32)) dut_fp (
    .hclk(hclk), .hreset_n(hreset_n), .m0(mif[2]), .m1(mif[3]), .s(sif[1])
  );

  int checks = 0;
  int errors = 0;

  // ---------------- reference model (transaction level) ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  sz;
  } xfer_t;

  bit    mw_valid [2][2];   // a transfer is waiting in the arbiter for master n
  xfer_t mw_x     [2][2];
  int    m_owner  [2];      // master in data phase, -1 when none
  int    m_wsel   [2];      // whose write data the slave currently sees
  int    m_last   [2];      // last master issued
  xfer_t m_hold   [2];      // last control seen by the slave

  bit          e_rdy  [2];
  logic [1:0]  e_resp [2];
  bit          e_grant;
  int          e_win;
  xfer_t       e_x;
  logic [31:0] e_hwdata;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      mw_valid[d][0] = 1'b0;
      mw_valid[d][1] = 1'b0;
      m_owner[d]     = -1;
      m_wsel[d]      = 0;
      m_last[d]      = 1;
      m_hold[d]      = '0;
    end
  endtask

  // Evaluate one cycle for instance d from the current inputs, then advance.
  task automatic model_step(input int d);
    bit    live [2];
    bit    want [2];
    xfer_t lx   [2];
    for (int n = 0; n < 2; n++) begin
      int k = d * 2 + n;
      e_rdy[n]  = mw_valid[d][n] ? 1'b0 : ((m_owner[d] == n) ? s_hready : 1'b1);
      e_resp[n] = (m_owner[d] == n) ? s_hresp : 2'b00;
      live[n]   = d_sel[k] && d_trans[k][1] && e_rdy[n];
      want[n]   = mw_valid[d][n] || live[n];
      lx[n]     = '{addr: d_addr[k], wr: d_wr[k], sz: d_sz[k]};
    end
    e_hwdata = d_wdata[d * 2 + m_wsel[d]];
    e_grant  = s_hready && (want[0] || want[1]);
    e_win    = 0;
    if (want[0] && want[1]) e_win = (d == 0) ? 1 - m_last[d] : 0;
    else if (want[1])       e_win = 1;
    if (e_grant) e_x = mw_valid[d][e_win] ? mw_x[d][e_win] : lx[e_win];
    else         e_x = m_hold[d];
    for (int n = 0; n < 2; n++) begin
      if (e_grant && e_win == n) mw_valid[d][n] = 1'b0;
      else if (live[n]) begin
        mw_valid[d][n] = 1'b1;
        mw_x[d][n]     = lx[n];
      end
    end
    if (e_grant) begin
      m_last[d]  = e_win;
      m_hold[d]  = e_x;
      m_owner[d] = e_win;
      m_wsel[d]  = e_win;
    end else if (s_hready) begin
      m_owner[d] = -1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_m(input int n, input bit sel, input bit [1:0] tr,
                       input bit wr, input bit [31:0] a);
    for (int d = 0; d < 2; d++) begin
      d_sel[d*2+n]   = sel;
      d_trans[d*2+n] = tr;
      d_wr[d*2+n]    = wr;
      d_sz[d*2+n]    = 3'b010;
      d_addr[d*2+n]  = a;
    end
  endtask

  task automatic set_wdata(input int n, input bit [31:0] v);
    for (int d = 0; d < 2; d++) d_wdata[d*2+n] = v;
  endtask

  task automatic apply_reset();
    hreset_n = 1'b0;
    set_m(0, 1'b0, 2'b00, 1'b0, 32'h0);
    set_m(1, 1'b0, 2'b00, 1'b0, 32'h0);
    s_hready = 1'b1;
    s_hresp  = 2'b00;
    repeat (2) @(posedge hclk);
    #2;
    hreset_n = 1'b1;
    model_reset();
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_ssel[d] !== 1'b0) begin errors++; $display("FAIL reset_hsel dut%0d got %0b want 0", d, o_ssel[d]); end
      checks++; if (o_strans[d] !== 2'b00) begin errors++; $display("FAIL reset_htrans dut%0d got %0b want 00", d, o_strans[d]); end
      checks++; if ({o_saddr[d], o_swr[d], o_ssz[d]} !== 36'h0) begin errors++; $display("FAIL reset_ctrl dut%0d got addr=%h wr=%0b sz=%0d want 0", d, o_saddr[d], o_swr[d], o_ssz[d]); end
      for (int n = 0; n < 2; n++) begin
        checks++; if (o_rdy[d*2+n] !== 1'b1) begin errors++; $display("FAIL reset_hready dut%0d m%0d got %0b want 1", d, n, o_rdy[d*2+n]); end
        checks++; if (o_resp[d*2+n] !== 2'b00) begin errors++; $display("FAIL reset_hresp dut%0d m%0d got %0b want 00", d, n, o_resp[d*2+n]); end
      end
    end
    $display("test_reset done");
    tick();
  endtask

  task automatic test_single_read();
    apply_reset();
    set_m(0, 1'b1, 2'b10, 1'b0, 32'h10);
    @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_strans[d] !== 2'b10 || o_ssel[d] !== 1'b1) begin errors++; $display("FAIL single_issue dut%0d got htrans=%0b hsel=%0b want 10/1", d, o_strans[d], o_ssel[d]); end
      checks++; if (o_saddr[d] !== 32'h10) begin errors++; $display("FAIL single_addr dut%0d got %h want 00000010", d, o_saddr[d]); end
      checks++; if (o_rdy[d*2] !== 1'b1) begin errors++; $display("FAIL single_hready dut%0d got %0b want 1", d, o_rdy[d*2]); end
    end
    tick();
    set_m(0, 1'b0, 2'b00, 1'b0, 32'h0);
    s_hrdata = 32'h1234_5678;
    @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_rdata[d*2] !== 32'h1234_5678) begin errors++; $display("FAIL single_rdata dut%0d got %h want 12345678", d, o_rdata[d*2]); end
      checks++; if (o_strans[d] !== 2'b00 || o_saddr[d] !== 32'h10) begin errors++; $display("FAIL single_idle_hold dut%0d got htrans=%0b addr=%h want 00/00000010", d, o_strans[d], o_saddr[d]); end
    end
    $display("test_single_read done");
    tick();
  endtask

  task automatic test_collision();
    apply_reset();
    set_m(0, 1'b1, 2'b10, 1'b0, 32'h100);
    set_m(1, 1'b1, 2'b10, 1'b1, 32'h200);
    @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_saddr[d] !== 32'h100 || o_swr[d] !== 1'b0) begin errors++; $display("FAIL coll_first dut%0d got addr=%h wr=%0b want 00000100/0", d, o_saddr[d], o_swr[d]); end
    end
    tick();
    set_m(0, 1'b0, 2'b00, 1'b0, 32'h0);
    set_m(1, 1'b0, 2'b00, 1'b0, 32'h0);
    set_wdata(0, 32'h0BAD_F00D);
    set_wdata(1, 32'hDEAD_BEEF);
    @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_rdy[d*2+1] !== 1'b0) begin errors++; $display("FAIL coll_m1_stall dut%0d got %0b want 0", d, o_rdy[d*2+1]); end
      checks++; if (o_strans[d] !== 2'b10 || o_saddr[d] !== 32'h200 || o_swr[d] !== 1'b1) begin errors++; $display("FAIL coll_second dut%0d got htrans=%0b addr=%h wr=%0b want 10/00000200/1", d, o_strans[d], o_saddr[d], o_swr[d]); end
      checks++; if (o_swdata[d] !== 32'h0BAD_F00D) begin errors++; $display("FAIL coll_wdata_m0 dut%0d got %h want 0badf00d", d, o_swdata[d]); end
    end
    tick();
    @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_swdata[d] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL coll_wdata_m1 dut%0d got %h want deadbeef", d, o_swdata[d]); end
      checks++; if (o_rdy[d*2+1] !== 1'b1 || o_strans[d] !== 2'b00) begin errors++; $display("FAIL coll_done dut%0d got hready=%0b htrans=%0b want 1/00", d, o_rdy[d*2+1], o_strans[d]); end
    end
    $display("test_collision done");
    tick();
  endtask

  task automatic test_rr_stream();
    bit r [4];
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      d_sel[k]   = 1'b1;
      d_trans[k] = 2'b10;
      d_wr[k]    = 1'b0;
      d_sz[k]    = 3'b010;
      d_addr[k]  = (k % 2 == 0) ? 32'h1000_0000 : 32'h2000_0000;
    end
    for (int i = 0; i < 8; i++) begin
      logic [31:0] exp_rr;
      logic [31:0] exp_fp;
      @(negedge hclk);
      exp_rr = ((i % 2 == 0) ? 32'h1000_0000 : 32'h2000_0000) + 32'(4 * (i / 2));
      exp_fp = 32'h1000_0000 + 32'(4 * i);
      checks++; if (o_strans[0] !== 2'b10 || o_saddr[0] !== exp_rr) begin errors++; $display("FAIL rr_grant cycle%0d got htrans=%0b addr=%h want 10/%h", i, o_strans[0], o_saddr[0], exp_rr); end
      checks++; if (o_strans[1] !== 2'b10 || o_saddr[1] !== exp_fp) begin errors++; $display("FAIL fp_grant cycle%0d got htrans=%0b addr=%h want 10/%h", i, o_strans[1], o_saddr[1], exp_fp); end
      for (int k = 0; k < 4; k++) r[k] = o_rdy[k];
      tick();
      for (int k = 0; k < 4; k++) if (r[k]) d_addr[k] = d_addr[k] + 32'd4;
    end
    $display("test_rr_stream done");
  endtask

  task automatic test_wait_states();
    apply_reset();
    set_m(0, 1'b1, 2'b10, 1'b0, 32'h40);
    @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_strans[d] !== 2'b10 || o_saddr[d] !== 32'h40) begin errors++; $display("FAIL ws_first dut%0d got htrans=%0b addr=%h want 10/00000040", d, o_strans[d], o_saddr[d]); end
    end
    tick();
    set_m(0, 1'b0, 2'b00, 1'b0, 32'h0);
    set_m(1, 1'b1, 2'b10, 1'b0, 32'h80);
    s_hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      for (int d = 0; d < 2; d++) begin
        checks++; if (o_strans[d] !== 2'b00 || o_rdy[d*2] !== 1'b0) begin errors++; $display("FAIL ws_stall dut%0d cycle%0d got htrans=%0b m0_hready=%0b want 00/0", d, i, o_strans[d], o_rdy[d*2]); end
        checks++; if (o_rdy[d*2+1] !== (i == 0)) begin errors++; $display("FAIL ws_m1_hready dut%0d cycle%0d got %0b want %0b", d, i, o_rdy[d*2+1], (i == 0)); end
      end
      tick();
      set_m(1, 1'b0, 2'b00, 1'b0, 32'h0);
    end
    s_hready = 1'b1;
    @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_strans[d] !== 2'b10 || o_saddr[d] !== 32'h80) begin errors++; $display("FAIL ws_release dut%0d got htrans=%0b addr=%h want 10/00000080", d, o_strans[d], o_saddr[d]); end
      checks++; if (o_rdy[d*2] !== 1'b1 || o_rdy[d*2+1] !== 1'b0) begin errors++; $display("FAIL ws_release_rdy dut%0d got m0=%0b m1=%0b want 1/0", d, o_rdy[d*2], o_rdy[d*2+1]); end
    end
    tick();
    @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_rdy[d*2+1] !== 1'b1 || o_strans[d] !== 2'b00) begin errors++; $display("FAIL ws_done dut%0d got m1_hready=%0b htrans=%0b want 1/00", d, o_rdy[d*2+1], o_strans[d]); end
    end
    $display("test_wait_states done");
    tick();
  endtask

  task automatic test_async_reset();
    apply_reset();
    set_m(0, 1'b1, 2'b10, 1'b0, 32'h500);
    set_m(1, 1'b1, 2'b10, 1'b0, 32'h600);
    tick();
    set_m(0, 1'b0, 2'b00, 1'b0, 32'h0);
    set_m(1, 1'b0, 2'b00, 1'b0, 32'h0);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_rdy[d*2+1] !== 1'b0) begin errors++; $display("FAIL ar_precond dut%0d m1_hready got %0b want 0", d, o_rdy[d*2+1]); end
    end
    hreset_n = 1'b0;
    @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_strans[d] !== 2'b00 || o_ssel[d] !== 1'b0 || o_saddr[d] !== 32'h0) begin errors++; $display("FAIL ar_slave dut%0d got htrans=%0b hsel=%0b addr=%h want 00/0/0", d, o_strans[d], o_ssel[d], o_saddr[d]); end
      checks++; if (o_rdy[d*2] !== 1'b1 || o_rdy[d*2+1] !== 1'b1) begin errors++; $display("FAIL ar_hready dut%0d got m0=%0b m1=%0b want 1/1", d, o_rdy[d*2], o_rdy[d*2+1]); end
    end
    #2;
    hreset_n = 1'b1;
    model_reset();
    tick();
    @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_strans[d] !== 2'b00 || o_rdy[d*2+1] !== 1'b1) begin errors++; $display("FAIL ar_after dut%0d got htrans=%0b m1_hready=%0b want 00/1", d, o_strans[d], o_rdy[d*2+1]); end
    end
    $display("test_async_reset done");
    tick();
  endtask

  task automatic test_error();
    apply_reset();
    set_m(1, 1'b1, 2'b10, 1'b0, 32'h300);
    @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_strans[d] !== 2'b10 || o_saddr[d] !== 32'h300) begin errors++; $display("FAIL err_issue dut%0d got htrans=%0b addr=%h want 10/00000300", d, o_strans[d], o_saddr[d]); end
    end
    tick();
    set_m(1, 1'b0, 2'b00, 1'b0, 32'h0);
    set_m(0, 1'b1, 2'b10, 1'b0, 32'h400);
    s_hready = 1'b0;
    s_hresp  = 2'b01;
    @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_resp[d*2+1] !== 2'b01 || o_resp[d*2] !== 2'b00) begin errors++; $display("FAIL err_c1_resp dut%0d got m1=%0b m0=%0b want 01/00", d, o_resp[d*2+1], o_resp[d*2]); end
      checks++; if (o_rdy[d*2+1] !== 1'b0 || o_rdy[d*2] !== 1'b1) begin errors++; $display("FAIL err_c1_rdy dut%0d got m1=%0b m0=%0b want 0/1", d, o_rdy[d*2+1], o_rdy[d*2]); end
    end
    tick();
    set_m(0, 1'b0, 2'b00, 1'b0, 32'h0);
    s_hready = 1'b1;
    @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_resp[d*2+1] !== 2'b01 || o_resp[d*2] !== 2'b00) begin errors++; $display("FAIL err_c2_resp dut%0d got m1=%0b m0=%0b want 01/00", d, o_resp[d*2+1], o_resp[d*2]); end
      checks++; if (o_rdy[d*2+1] !== 1'b1 || o_rdy[d*2] !== 1'b0) begin errors++; $display("FAIL err_c2_rdy dut%0d got m1=%0b m0=%0b want 1/0", d, o_rdy[d*2+1], o_rdy[d*2]); end
      checks++; if (o_strans[d] !== 2'b10 || o_saddr[d] !== 32'h400) begin errors++; $display("FAIL err_pending_issue dut%0d got htrans=%0b addr=%h want 10/00000400", d, o_strans[d], o_saddr[d]); end
    end
    tick();
    s_hresp = 2'b00;
    @(negedge hclk);
    for (int d = 0; d < 2; d++) begin
      checks++; if (o_resp[d*2] !== 2'b00 || o_rdy[d*2] !== 1'b1) begin errors++; $display("FAIL err_m0_done dut%0d got resp=%0b hready=%0b want 00/1", d, o_resp[d*2], o_rdy[d*2]); end
    end
    $display("test_error done");
    tick();
  endtask

  task automatic test_random();
    bit prev_rdy [4];
    apply_reset();
    for (int k = 0; k < 4; k++) prev_rdy[k] = 1'b1;
    for (int c = 0; c < 300; c++) begin
      s_hready = ($urandom % 4) != 0;
      s_hresp  = ($urandom % 8 == 0) ? 2'b01 : 2'b00;
      s_hrdata = $urandom;
      for (int k = 0; k < 4; k++) begin
        if (prev_rdy[k]) begin
          d_sel[k]   = ($urandom % 10) != 0;
          d_trans[k] = ($urandom % 5 < 3) ? 2'b10 : 2'b00;
          d_wr[k]    = 1'($urandom % 2);
          d_sz[k]    = 3'($urandom % 3);
          d_addr[k]  = $urandom & 32'hFFFF_FFFC;
          d_wdata[k] = $urandom;
        end
      end
      @(negedge hclk);
      for (int d = 0; d < 2; d++) begin
        model_step(d);
        for (int n = 0; n < 2; n++) begin
          checks++; if (o_rdy[d*2+n] !== e_rdy[n]) begin errors++; $display("FAIL rnd_hready c%0d dut%0d m%0d got %0b want %0b", c, d, n, o_rdy[d*2+n], e_rdy[n]); end
          checks++; if (o_resp[d*2+n] !== e_resp[n]) begin errors++; $display("FAIL rnd_hresp c%0d dut%0d m%0d got %0b want %0b", c, d, n, o_resp[d*2+n], e_resp[n]); end
          checks++; if (o_rdata[d*2+n] !== s_hrdata) begin errors++; $display("FAIL rnd_hrdata c%0d dut%0d m%0d got %h want %h", c, d, n, o_rdata[d*2+n], s_hrdata); end
        end
        checks++; if (o_ssel[d] !== e_grant || o_strans[d] !== (e_grant ? 2'b10 : 2'b00)) begin errors++; $display("FAIL rnd_issue c%0d dut%0d got hsel=%0b htrans=%0b want grant=%0b", c, d, o_ssel[d], o_strans[d], e_grant); end
        checks++; if ({o_saddr[d], o_swr[d], o_ssz[d]} !== {e_x.addr, e_x.wr, e_x.sz}) begin errors++; $display("FAIL rnd_ctrl c%0d dut%0d got addr=%h wr=%0b sz=%0d want addr=%h wr=%0b sz=%0d", c, d, o_saddr[d], o_swr[d], o_ssz[d], e_x.addr, e_x.wr, e_x.sz); end
        checks++; if (o_swdata[d] !== e_hwdata) begin errors++; $display("FAIL rnd_hwdata c%0d dut%0d got %h want %h", c, d, o_swdata[d], e_hwdata); end
        if (e_grant) $display("txn c%0d dut%0d m%0d %s addr=%h sz=%0d", c, d, e_win, e_x.wr ? "WR" : "RD", e_x.addr, e_x.sz);
      end
      for (int k = 0; k < 4; k++) prev_rdy[k] = o_rdy[k];
      tick();
    end
    $display("test_random done");
  endtask

  initial begin
    hreset_n = 1'b0;
    s_hready = 1'b1;
    s_hresp  = 2'b00;
    s_hrdata = 32'h0;
    for (int k = 0; k < 4; k++) d_wdata[k] = 32'h0;
    set_m(0, 1'b0, 2'b00, 1'b0, 32'h0);
    set_m(1, 1'b0, 2'b00, 1'b0, 32'h0);
    model_reset();
    test_reset();
    test_single_read();
    test_collision();
    test_rr_stream();
    test_wait_states();
    test_async_reset();
    test_error();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
